mem_check_monitor: RTL
======================

MEM_CHECK_MONITOR -- requirements
Module: mem_check_monitor

Interface
REQ-001 Parameter ADDR_W, 10, data-memory word-address width.
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter BASE_ADDR, 369, first word index of the checked window.
REQ-004 Parameter CHECK_LEN, 10, number of words checked (1..2^ADDR_W-BASE_ADDR).
REQ-005 Parameter TIMEOUT, 50000, maximum RUN cycles before a forced check.
REQ-006 Parameter CNT_W, 32, width of the cycle, mismatch and flush counters.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst_BF  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  single-cycle pulse that arms a new run.
REQ-010 halt  in  1  core finished; sampled only in RUN.
REQ-011 flush  in  1  pipeline-flush (misprediction) pulse from the core.
REQ-012 mem_rd_en  out  1  read strobe to data memory.
REQ-013 mem_addr  out  ADDR_W  word address of the read.
REQ-014 exp_idx  out  ADDR_W  offset (0..CHECK_LEN-1) into the expected-value table, driven with mem_addr.
REQ-015 mem_rd_data  in  DATA_W  memory data, valid the cycle after mem_rd_en.
REQ-016 exp_data  in  DATA_W  expected value, valid the same cycle as mem_rd_data.
REQ-017 done  out  1  check complete; results stable.
REQ-018 pass  out  1  done AND no timeout AND mismatch_cnt==0.
REQ-019 timeout  out  1  RUN ended by TIMEOUT rather than halt.
REQ-020 mismatch_cnt  out  CNT_W  number of words differing from expected.
REQ-021 first_fail_idx  out  ADDR_W  offset of the lowest mismatching word; 0 if none.
REQ-022 flush_cnt  out  CNT_W  flush pulses counted during RUN (see Configuration).

Function
REQ-023 FSM states IDLE, RUN, READ, DRAIN, DONE; the block SHALL hold one state per cycle.
REQ-024 IDLE->RUN and DONE->RUN on start; entering RUN clears cycle counter, mismatch_cnt, first_fail_idx, flush_cnt, timeout, done.
REQ-025 start in RUN, READ or DRAIN SHALL be ignored.
REQ-026 RUN: cycle counter +1 per cycle; halt=1 -> READ; counter==TIMEOUT-1 with halt=0 -> READ and timeout set to 1; halt wins if both occur in the same cycle (timeout stays 0).
REQ-027 READ: mem_rd_en=1 each cycle, mem_addr=BASE_ADDR+k, exp_idx=k, k=0..CHECK_LEN-1 back-to-back; after k=CHECK_LEN-1 -> DRAIN.
REQ-028 Compare pipelined: data for offset k compared in the cycle after its issue; on mismatch mismatch_cnt +1 (saturating at all ones) and first_fail_idx=k if this is the first mismatch of the run.
REQ-029 DRAIN: one cycle, compares the last word, mem_rd_en=0, -> DONE.
REQ-030 DONE: done=1, pass per REQ-018, all results held until next start.
REQ-031 Total latency halt-to-done SHALL be CHECK_LEN+2 cycles.
REQ-032 Address arithmetic SHALL be ADDR_W bits; BASE_ADDR+CHECK_LEN-1 SHALL not wrap (elaboration error if it exceeds 2^ADDR_W-1).
REQ-033 mem_rd_en and exp_idx SHALL be 0 outside READ; pass SHALL be 0 whenever done=0.

Reset
REQ-034 rst_BF=0 SHALL immediately force IDLE and all outputs and counters to 0, including mid-READ; no partial result survives.
REQ-035 After rst_BF deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-036 Macro MISPREDICT_COUNT_EN: when defined, flush_cnt counts cycles with flush=1 in RUN, saturating at all ones; when undefined, the counter is not built and flush_cnt is tied to 0.

Verification
REQ-037 Reset, start, halt after 100 cycles, memory holds 1,23,45,50,100,121,200,432,564,788 at 369..378 equal to exp_data -> done after 12 cycles, pass=1, mismatch_cnt=0.
REQ-038 Same, but word 373 = 99 and word 376 = 0 -> pass=0, mismatch_cnt=2, first_fail_idx=4.
REQ-039 TIMEOUT=20, halt never asserted -> READ entered after 20 RUN cycles, timeout=1, pass=0 even if all words match.
REQ-040 With MISPREDICT_COUNT_EN defined, 7 flush pulses during RUN and 3 in IDLE -> flush_cnt=7; without the macro -> flush_cnt=0.
REQ-041 rst_BF asserted on the 4th READ cycle -> all outputs 0 same cycle; new start runs a full clean check with correct results.
REQ-042 start asserted during READ -> ignored; start in DONE -> results cleared, new run begins.

Source files
------------

// File: rtl/mem_check_monitor.sv
// mem_check_monitor: after the core halts (or times out) reads a data-memory window and compares it
// word by word against an expected-value table. Define MISPREDICT_COUNT_EN to build the flush counter.
module mem_check_monitor #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 369,
  parameter int CHECK_LEN = 10,
  parameter int TIMEOUT   = 50000,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_BF,
  input  logic              start,
  input  logic              halt,
  input  logic              flush,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] exp_idx,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] exp_data,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(CHECK_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // The checked window must fit the address space without wrapping.
  generate
    if ((BASE_ADDR + CHECK_LEN - 1) > ((1 << ADDR_W) - 1)) begin : g_bad_window
      $error("mem_check_monitor: BASE_ADDR+CHECK_LEN-1 exceeds the address space");
    end
    if (CHECK_LEN < 1 || TIMEOUT < 1) begin : g_bad_len
      $error("mem_check_monitor: CHECK_LEN and TIMEOUT must be at least 1");
    end
  endgenerate

  state_t              state_r, state_nxt_s;
  logic                arm_s, tmo_hit_s, mm_hit_s, rd_nxt_s;
  logic [ADDR_W-1:0]   idx_nxt_s;
  logic                mem_rd_en_r, cmp_vld_r;
  logic [ADDR_W-1:0]   mem_addr_r, exp_idx_r, cmp_idx_r, first_fail_idx_r;
  logic [CNT_W-1:0]    cyc_cnt_r, mismatch_cnt_r, flush_cnt_r;
  logic                timeout_r, done_r, pass_r;

  // State register.
  always_ff @(posedge clk or negedge rst_BF) begin
    if (!rst_BF) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus the per-cycle strobes derived from it.
  always_comb begin
    state_nxt_s = state_r;
    arm_s       = 1'b0;
    tmo_hit_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          arm_s       = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt_s = ST_READ;
        end else if (cyc_cnt_r == TMO_LAST) begin
          state_nxt_s = ST_READ;
          tmo_hit_s   = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_READ: begin
        if (exp_idx_r == K_LAST) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DRAIN: state_nxt_s = ST_DONE;
      default:  state_nxt_s = ST_IDLE;
    endcase

    rd_nxt_s = (state_nxt_s == ST_READ);
    if (rd_nxt_s && (state_r == ST_READ)) begin
      idx_nxt_s = exp_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      idx_nxt_s = ADDR_ZERO;
    end

    if (cmp_vld_r && (mem_rd_data != exp_data)) begin
      mm_hit_s = 1'b1;
    end else begin
      mm_hit_s = 1'b0;
    end
  end

  // Read issue; the compare stage trails it by exactly one cycle to meet the memory latency.
  always_ff @(posedge clk or negedge rst_BF) begin
    if (!rst_BF) begin
      mem_rd_en_r <= 1'b0;
      exp_idx_r   <= ADDR_ZERO;
      mem_addr_r  <= ADDR_ZERO;
      cmp_vld_r   <= 1'b0;
      cmp_idx_r   <= ADDR_ZERO;
    end else begin
      mem_rd_en_r <= rd_nxt_s;
      exp_idx_r   <= idx_nxt_s;
      mem_addr_r  <= rd_nxt_s ? (BASE_A + idx_nxt_s) : ADDR_ZERO;
      cmp_vld_r   <= mem_rd_en_r;
      cmp_idx_r   <= exp_idx_r;
    end
  end

  // RUN cycle counter and timeout flag.
  always_ff @(posedge clk or negedge rst_BF) begin
    if (!rst_BF) begin
      cyc_cnt_r <= CNT_ZERO;
      timeout_r <= 1'b0;
    end else if (arm_s) begin
      cyc_cnt_r <= CNT_ZERO;
      timeout_r <= 1'b0;
    end else if (state_r == ST_RUN) begin
      cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
      timeout_r <= timeout_r | tmo_hit_s;
    end else begin
      cyc_cnt_r <= cyc_cnt_r;
      timeout_r <= timeout_r;
    end
  end

  // Mismatch accounting; a zero count means no earlier failure in this run.
  always_ff @(posedge clk or negedge rst_BF) begin
    if (!rst_BF) begin
      mismatch_cnt_r   <= CNT_ZERO;
      first_fail_idx_r <= ADDR_ZERO;
    end else if (arm_s) begin
      mismatch_cnt_r   <= CNT_ZERO;
      first_fail_idx_r <= ADDR_ZERO;
    end else if (mm_hit_s) begin
      mismatch_cnt_r   <= (mismatch_cnt_r == CNT_MAX) ? CNT_MAX : (mismatch_cnt_r + CNT_ONE);
      first_fail_idx_r <= (mismatch_cnt_r == CNT_ZERO) ? cmp_idx_r : first_fail_idx_r;
    end else begin
      mismatch_cnt_r   <= mismatch_cnt_r;
      first_fail_idx_r <= first_fail_idx_r;
    end
  end

  // Completion; pass folds in the final compare made during DRAIN.
  always_ff @(posedge clk or negedge rst_BF) begin
    if (!rst_BF) begin
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else if (arm_s) begin
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else if (state_r == ST_DRAIN) begin
      done_r <= 1'b1;
      pass_r <= !timeout_r && (mismatch_cnt_r == CNT_ZERO) && !mm_hit_s;
    end else begin
      done_r <= done_r;
      pass_r <= pass_r;
    end
  end

`ifdef MISPREDICT_COUNT_EN
  // Flush pulses seen while the core runs, saturating.
  always_ff @(posedge clk or negedge rst_BF) begin
    if (!rst_BF) begin
      flush_cnt_r <= CNT_ZERO;
    end else if (arm_s) begin
      flush_cnt_r <= CNT_ZERO;
    end else if ((state_r == ST_RUN) && flush && (flush_cnt_r != CNT_MAX)) begin
      flush_cnt_r <= flush_cnt_r + CNT_ONE;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end
`else
  logic unused_flush_s;
  assign unused_flush_s = flush;
  assign flush_cnt_r    = CNT_ZERO;
`endif

  assign mem_rd_en      = mem_rd_en_r;
  assign mem_addr       = mem_addr_r;
  assign exp_idx        = exp_idx_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign timeout        = timeout_r;
  assign mismatch_cnt   = mismatch_cnt_r;
  assign first_fail_idx = first_fail_idx_r;
  assign flush_cnt      = flush_cnt_r;

endmodule
